// File: rtl/hist2d_readout_if.sv
// Bus bundle for hist2d_readout: histogram update port, command strobes,
// readout stream and status flags.
interface hist2d_if;
  logic        i_q_found;
  logic [7:0]  i_bin_coord;
  logic [7:0]  q_bin_coord;
  logic [15:0] bin_val;
  logic [7:0]  i_bin_num;
  logic [7:0]  q_bin_num;
  logic        clear_start;
  logic        dump_start;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_i;
  logic [7:0]  out_q;
  logic [15:0] out_val;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        drop_err;
  logic        range_err;

  modport slave (
    input  i_q_found, i_bin_coord, q_bin_coord, bin_val,
    input  i_bin_num, q_bin_num, clear_start, dump_start, out_ready,
    output out_valid, out_i, out_q, out_val, out_last,
    output busy, done, drop_err, range_err
  );

  modport master (
    output i_q_found, i_bin_coord, q_bin_coord, bin_val,
    output i_bin_num, q_bin_num, clear_start, dump_start, out_ready,
    input  out_valid, out_i, out_q, out_val, out_last,
    input  busy, done, drop_err, range_err
  );
endinterface

// File: rtl/hist2d_readout.sv
// 2-D histogram bin store: accepts bin updates, clears all bins, and streams
// a rectangular window of bins out over a valid/ready handshake.
module hist2d_readout #(
  parameter int unsigned AXIS_MAX = 16
) (
  input  logic    clk100,
  input  logic    rst,
  hist2d_if.slave bus
);

  localparam int unsigned NBINS = AXIS_MAX * AXIS_MAX;
  localparam int unsigned AW    = (NBINS > 1) ? $clog2(NBINS) : 1;
  localparam int unsigned NW    = 9;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DUMP} state_e;

  state_e state_q, state_d;

  logic [15:0]   bin_mem_q [NBINS];
  logic [15:0]   rdata_q;
  logic          we_c;
  logic [AW-1:0] waddr_c;
  logic [AW-1:0] raddr_c;
  logic [15:0]   wdata_c;

  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [NW-1:0] ni_q, ni_d, nq_q, nq_d;
  logic [7:0]    iss_i_q, iss_i_d, iss_q_q, iss_q_d;
  logic          iss_done_q, iss_done_d;
  logic          dv_q, dv_d;
  logic [7:0]    d_i_q, d_i_d, d_q_q, d_q_d;
  logic          d_last_q, d_last_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_i_q, out_i_d, out_q_q, out_q_d;
  logic [15:0]   out_val_q, out_val_d;
  logic          out_last_q, out_last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          drop_err_q, drop_err_d;
  logic          range_err_q, range_err_d;

  logic          in_range_c;
  logic [NW-1:0] ni_clamp_c, nq_clamp_c;
  logic          iss_last_i_c, iss_last_q_c;
  logic          load_out_c, issue_c, xfer_c;

  function automatic logic [AW-1:0] bin_addr(input logic [7:0] i, input logic [7:0] q);
    return AW'(32'(q) * AXIS_MAX + 32'(i));
  endfunction

  assign in_range_c   = (32'(bus.i_bin_coord) < AXIS_MAX) && (32'(bus.q_bin_coord) < AXIS_MAX);
  assign ni_clamp_c   = (32'(bus.i_bin_num) > AXIS_MAX) ? NW'(AXIS_MAX) : NW'(bus.i_bin_num);
  assign nq_clamp_c   = (32'(bus.q_bin_num) > AXIS_MAX) ? NW'(AXIS_MAX) : NW'(bus.q_bin_num);
  assign iss_last_i_c = (NW'(iss_i_q) == ni_q - NW'(1));
  assign iss_last_q_c = (NW'(iss_q_q) == nq_q - NW'(1));

  // Three-stage readout: issue address -> read data (dv) -> output beat.
  // A stalled read stage keeps re-reading its own address, so rdata stays valid.
  assign load_out_c = dv_q && (!out_valid_q || bus.out_ready);
  assign issue_c    = (state_q == ST_DUMP) && !iss_done_q && (!dv_q || load_out_c);
  assign xfer_c     = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    ni_d        = ni_q;
    nq_d        = nq_q;
    iss_i_d     = iss_i_q;
    iss_q_d     = iss_q_q;
    iss_done_d  = iss_done_q;
    dv_d        = dv_q;
    d_i_d       = d_i_q;
    d_q_d       = d_q_q;
    d_last_d    = d_last_q;
    out_valid_d = out_valid_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    out_val_d   = out_val_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    drop_err_d  = drop_err_q;
    range_err_d = range_err_q;
    we_c        = 1'b0;
    waddr_c     = '0;
    wdata_c     = '0;
    raddr_c     = issue_c ? bin_addr(iss_i_q, iss_q_q) : bin_addr(d_i_q, d_q_q);

    if (bus.i_q_found) begin
      if (!in_range_c)          range_err_d = 1'b1;
      if (state_q != ST_IDLE)   drop_err_d  = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.i_q_found && in_range_c) begin
          we_c    = 1'b1;
          waddr_c = bin_addr(bus.i_bin_coord, bus.q_bin_coord);
          wdata_c = bus.bin_val;
        end
        if (bus.clear_start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (bus.dump_start) begin
          ni_d        = ni_clamp_c;
          nq_d        = nq_clamp_c;
          iss_i_d     = '0;
          iss_q_d     = '0;
          iss_done_d  = 1'b0;
          dv_d        = 1'b0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          // An empty window finishes immediately without entering DUMP.
          if (ni_clamp_c == '0 || nq_clamp_c == '0) done_d  = 1'b1;
          else                                      state_d = ST_DUMP;
        end
      end

      ST_CLEAR: begin
        we_c      = 1'b1;
        waddr_c   = clr_cnt_q;
        wdata_c   = '0;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(NBINS - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      ST_DUMP: begin
        if (issue_c) begin
          dv_d     = 1'b1;
          d_i_d    = iss_i_q;
          d_q_d    = iss_q_q;
          d_last_d = iss_last_i_c && iss_last_q_c;
          if (iss_last_i_c) begin
            iss_i_d = '0;
            if (iss_last_q_c) iss_done_d = 1'b1;
            else              iss_q_d    = iss_q_q + 8'd1;
          end else begin
            iss_i_d = iss_i_q + 8'd1;
          end
        end else if (load_out_c) begin
          dv_d = 1'b0;
        end

        if (load_out_c) begin
          out_valid_d = 1'b1;
          out_i_d     = d_i_q;
          out_q_d     = d_q_q;
          out_val_d   = rdata_q;
          out_last_d  = d_last_q;
        end else if (xfer_c) begin
          out_valid_d = 1'b0;
        end

        if (xfer_c && out_last_q) begin
          state_d     = ST_IDLE;
          done_d      = 1'b1;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clr_cnt_q   <= '0;
      ni_q        <= '0;
      nq_q        <= '0;
      iss_i_q     <= '0;
      iss_q_q     <= '0;
      iss_done_q  <= 1'b0;
      dv_q        <= 1'b0;
      d_i_q       <= '0;
      d_q_q       <= '0;
      d_last_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_val_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drop_err_q  <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      ni_q        <= ni_d;
      nq_q        <= nq_d;
      iss_i_q     <= iss_i_d;
      iss_q_q     <= iss_q_d;
      iss_done_q  <= iss_done_d;
      dv_q        <= dv_d;
      d_i_q       <= d_i_d;
      d_q_q       <= d_q_d;
      d_last_q    <= d_last_d;
      out_valid_q <= out_valid_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_val_q   <= out_val_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      drop_err_q  <= drop_err_d;
      range_err_q <= range_err_d;
    end
  end

  // Bin memory is deliberately not reset; only CLEAR defines its contents.
  always_ff @(posedge clk100) begin
    if (we_c && !rst) bin_mem_q[waddr_c] <= wdata_c;
    rdata_q <= bin_mem_q[raddr_c];
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_i     = out_i_q;
  assign bus.out_q     = out_q_q;
  assign bus.out_val   = out_val_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.drop_err  = drop_err_q;
  assign bus.range_err = range_err_q;

endmodule

// File: tb/tb_hist2d_readout.sv
// Self-checking bench for hist2d_readout: random updates and dump windows
// compared against a 2-D array model of the bins.
module tb_hist2d_readout;
  localparam int AXM = 16;

  logic clk100 = 1'b0;
  logic rst;
  hist2d_if bus();

  hist2d_readout #(.AXIS_MAX(AXM)) dut (.clk100(clk100), .rst(rst), .bus(bus));

  always #5 clk100 = ~clk100;

  int errors = 0;
  int checks = 0;

  logic [15:0] model [AXM][AXM];

  logic [7:0]  got_i [$];
  logic [7:0]  got_q [$];
  logic [15:0] got_v [$];
  logic        got_l [$];
  int first_valid_k, last_beat_k, done_k, done_cnt, stall_bad, valid_after_done;
  int busy_cnt, valid_cnt;

  task automatic tick;
    @(posedge clk100);
    #1;
  endtask

  task automatic idle_inputs;
    bus.i_q_found   = 1'b0;
    bus.i_bin_coord = '0;
    bus.q_bin_coord = '0;
    bus.bin_val     = '0;
    bus.i_bin_num   = '0;
    bus.q_bin_num   = '0;
    bus.clear_start = 1'b0;
    bus.dump_start  = 1'b0;
    bus.out_ready   = 1'b0;
  endtask

  function automatic int clampn(input int n);
    return (n > AXM) ? AXM : n;
  endfunction

  // One update strobe issued in IDLE; the model keeps in-range writes only.
  task automatic do_update(input int i, input int q, input logic [15:0] v);
    bus.i_q_found   = 1'b1;
    bus.i_bin_coord = 8'(i);
    bus.q_bin_coord = 8'(q);
    bus.bin_val     = v;
    tick;
    bus.i_q_found   = 1'b0;
    if (i < AXM && q < AXM) model[i][q] = v;
  endtask

  // Issue a command strobe and gather busy/done/valid statistics until done.
  task automatic run_cmd(input bit with_dump);
    busy_cnt = 0; valid_cnt = 0; done_k = -1; done_cnt = 0;
    bus.clear_start = 1'b1;
    bus.dump_start  = with_dump;
    bus.i_bin_num   = 8'd4;
    bus.q_bin_num   = 8'd4;
    bus.out_ready   = 1'b1;
    tick;
    bus.clear_start = 1'b0;
    bus.dump_start  = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (bus.done) begin done_cnt++; if (done_k < 0) done_k = k; end
      if (bus.busy) busy_cnt++;
      if (bus.out_valid) valid_cnt++;
      if (done_k >= 0 && k >= done_k + 3) break;
      bus.dump_start = (k == 10);
      tick;
    end
    bus.dump_start = 1'b0;
    bus.out_ready  = 1'b0;
  endtask

  // Run a dump, recording every transferred beat and handshake timing.
  task automatic run_dump(input int ni, input int nq, input int mode, input bit inject);
    logic rdy, prev_stall;
    logic [7:0] h_i, h_q; logic [15:0] h_v; logic h_l;
    got_i.delete(); got_q.delete(); got_v.delete(); got_l.delete();
    first_valid_k = -1; last_beat_k = -1; done_k = -1; done_cnt = 0;
    stall_bad = 0; valid_after_done = 0; prev_stall = 1'b0;
    h_i = '0; h_q = '0; h_v = '0; h_l = 1'b0;
    bus.i_bin_num  = 8'(ni);
    bus.q_bin_num  = 8'(nq);
    bus.dump_start = 1'b1;
    tick;
    bus.dump_start = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (bus.done) begin done_cnt++; if (done_k < 0) done_k = k; end
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_i !== h_i || bus.out_q !== h_q ||
                         bus.out_val !== h_v || bus.out_last !== h_l)) stall_bad++;
      if (bus.out_valid && first_valid_k < 0) first_valid_k = k;
      if (done_k >= 0 && bus.out_valid) valid_after_done++;
      if (done_k >= 0 && k >= done_k + 3) break;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((k % 3) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      if (inject && k == 3) begin
        bus.i_q_found = 1'b1; bus.i_bin_coord = 8'd1; bus.q_bin_coord = 8'd0; bus.bin_val = 16'h7777;
      end else begin
        bus.i_q_found = 1'b0;
      end
      if (bus.out_valid && rdy) begin
        got_i.push_back(bus.out_i); got_q.push_back(bus.out_q);
        got_v.push_back(bus.out_val); got_l.push_back(bus.out_last);
        last_beat_k = k;
      end
      prev_stall = bus.out_valid && !rdy;
      h_i = bus.out_i; h_q = bus.out_q; h_v = bus.out_val; h_l = bus.out_last;
      tick;
    end
    bus.out_ready = 1'b0;
    bus.i_q_found = 1'b0;
  endtask

  // Count beats that disagree with the model's row-major (i fastest) window.
  function automatic int dump_mismatches(input int ni, input int nq);
    int bad = 0;
    int idx = 0;
    if (got_v.size() != ni * nq) bad++;
    for (int q = 0; q < nq; q++) begin
      for (int i = 0; i < ni; i++) begin
        if (idx < got_v.size()) begin
          if (got_i[idx] !== 8'(i) || got_q[idx] !== 8'(q) || got_v[idx] !== model[i][q] ||
              got_l[idx] !== ((i == ni - 1) && (q == nq - 1))) bad++;
        end
        idx++;
      end
    end
    return bad;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    bus.i_q_found = 1'b1; bus.bin_val = 16'h1234;
    bus.clear_start = 1'b1; bus.dump_start = 1'b1; bus.i_bin_num = 8'd4; bus.q_bin_num = 8'd4;
    tick; tick;
    checks++;
    if ({bus.out_valid, bus.out_last, bus.busy, bus.done, bus.drop_err, bus.range_err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000",
        {bus.out_valid, bus.out_last, bus.busy, bus.done, bus.drop_err, bus.range_err});
    end
    checks++;
    if ({bus.out_i, bus.out_q, bus.out_val} !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {bus.out_i, bus.out_q, bus.out_val});
    end
    rst = 1'b0;
    idle_inputs;
    tick; tick;
    checks++;
    if ({bus.busy, bus.done, bus.out_valid} !== 3'b0) begin
      errors++; $display("FAIL reset_cmds_ignored: got %b expected 000", {bus.busy, bus.done, bus.out_valid});
    end
  endtask

  task automatic test_clear;
    run_cmd(1'b0);
    for (int i = 0; i < AXM; i++) for (int q = 0; q < AXM; q++) model[i][q] = 16'h0;
    checks++;
    if (done_k !== 256) begin errors++; $display("FAIL clear_done_time: got %0d expected 256", done_k); end
    checks++;
    if (busy_cnt !== 256 || done_cnt !== 1) begin
      errors++; $display("FAIL clear_busy_done: busy %0d done %0d expected 256 1", busy_cnt, done_cnt);
    end
    checks++;
    if (valid_cnt !== 0) begin errors++; $display("FAIL clear_dump_ignored: valid %0d expected 0", valid_cnt); end
    run_dump(16, 16, 0, 1'b0);
    checks++;
    if (dump_mismatches(16, 16) !== 0) begin
      errors++; $display("FAIL clear_dump: bad %0d beats %0d expected 0 256", dump_mismatches(16, 16), got_v.size());
    end
    checks++;
    if (first_valid_k < 0 || first_valid_k > 2) begin
      errors++; $display("FAIL first_latency: got %0d expected <=2", first_valid_k);
    end
    checks++;
    if (last_beat_k - first_valid_k !== 255) begin
      errors++; $display("FAIL throughput: span %0d expected 255", last_beat_k - first_valid_k);
    end
    checks++;
    if (done_k !== last_beat_k + 1 || done_cnt !== 1 || valid_after_done !== 0) begin
      errors++; $display("FAIL dump_done: done_k %0d cnt %0d vad %0d expected %0d 1 0",
        done_k, done_cnt, valid_after_done, last_beat_k + 1);
    end
  endtask

  task automatic test_updates;
    do_update(0, 0, 16'd1);
    do_update(1, 0, 16'd1);
    do_update(1, 0, 16'd2);
    do_update(2, 3, 16'd1);
    run_dump(4, 4, 0, 1'b0);
    checks++;
    if (got_v.size() !== 16) begin errors++; $display("FAIL upd_count: got %0d expected 16", got_v.size()); end
    else begin
      checks++;
      if (got_v[0] !== 16'd1 || got_v[1] !== 16'd2 || got_v[14] !== 16'd1 || got_v[15] !== 16'd0) begin
        errors++; $display("FAIL upd_values: got %0d %0d %0d %0d expected 1 2 1 0",
          got_v[0], got_v[1], got_v[14], got_v[15]);
      end
    end
    checks++;
    if (dump_mismatches(4, 4) !== 0) begin
      errors++; $display("FAIL upd_dump: bad %0d expected 0", dump_mismatches(4, 4));
    end
  endtask

  task automatic test_stall;
    do_update(2, 1, 16'hA5A5);
    run_dump(3, 2, 1, 1'b0);
    checks++;
    if (dump_mismatches(3, 2) !== 0) begin
      errors++; $display("FAIL stall_dump: bad %0d beats %0d expected 0 6", dump_mismatches(3, 2), got_v.size());
    end
    checks++;
    if (stall_bad !== 0 || done_cnt !== 1) begin
      errors++; $display("FAIL stall_hold: unstable %0d done %0d expected 0 1", stall_bad, done_cnt);
    end
  endtask

  task automatic test_range;
    do_update(16, 0, 16'hBEEF);
    do_update(3, 16, 16'hBEEF);
    tick;
    checks++;
    if (bus.range_err !== 1'b1 || bus.drop_err !== 1'b0) begin
      errors++; $display("FAIL range_flag: range %b drop %b expected 1 0", bus.range_err, bus.drop_err);
    end
    run_dump(4, 4, 2, 1'b0);
    checks++;
    if (dump_mismatches(4, 4) !== 0) begin
      errors++; $display("FAIL range_dump: bad %0d expected 0", dump_mismatches(4, 4));
    end
  endtask

  task automatic test_drop;
    run_dump(4, 4, 0, 1'b1);
    checks++;
    if (bus.drop_err !== 1'b1) begin errors++; $display("FAIL drop_flag: got %b expected 1", bus.drop_err); end
    checks++;
    if (dump_mismatches(4, 4) !== 0) begin
      errors++; $display("FAIL drop_dump: bad %0d expected 0", dump_mismatches(4, 4));
    end
    run_dump(4, 4, 2, 1'b0);
    checks++;
    if (dump_mismatches(4, 4) !== 0) begin
      errors++; $display("FAIL drop_redump: bad %0d expected 0", dump_mismatches(4, 4));
    end
  endtask

  task automatic test_collision;
    do_update(5, 5, 16'h0055);
    run_cmd(1'b1);
    for (int i = 0; i < AXM; i++) for (int q = 0; q < AXM; q++) model[i][q] = 16'h0;
    checks++;
    if (done_k !== 256 || valid_cnt !== 0 || done_cnt !== 1) begin
      errors++; $display("FAIL collision: done_k %0d valid %0d done %0d expected 256 0 1", done_k, valid_cnt, done_cnt);
    end
    run_dump(8, 8, 0, 1'b0);
    checks++;
    if (dump_mismatches(8, 8) !== 0) begin
      errors++; $display("FAIL collision_dump: bad %0d expected 0", dump_mismatches(8, 8));
    end
  endtask

  task automatic test_empty;
    run_dump(0, 5, 0, 1'b0);
    checks++;
    if (got_v.size() !== 0 || done_k !== 0 || done_cnt !== 1) begin
      errors++; $display("FAIL empty_i: beats %0d done_k %0d cnt %0d expected 0 0 1", got_v.size(), done_k, done_cnt);
    end
    run_dump(7, 0, 0, 1'b0);
    checks++;
    if (got_v.size() !== 0 || done_k !== 0 || done_cnt !== 1) begin
      errors++; $display("FAIL empty_q: beats %0d done_k %0d cnt %0d expected 0 0 1", got_v.size(), done_k, done_cnt);
    end
  endtask

  task automatic test_clamp;
    do_update(15, 1, 16'hFFFF);
    do_update(15, 0, 16'h8001);
    run_dump(200, 2, 2, 1'b0);
    checks++;
    if (dump_mismatches(16, 2) !== 0) begin
      errors++; $display("FAIL clamp_dump: bad %0d beats %0d expected 0 32", dump_mismatches(16, 2), got_v.size());
    end
  endtask

  task automatic test_random;
    int ni, nq;
    for (int it = 0; it < 6; it++) begin
      for (int u = 0; u < 10; u++)
        do_update(int'($urandom_range(0, 17)), int'($urandom_range(0, 17)), 16'($urandom));
      ni = int'($urandom_range(0, 18));
      nq = int'($urandom_range(0, 18));
      run_dump(ni, nq, 2, 1'b0);
      checks++;
      if (dump_mismatches(clampn(ni), clampn(nq)) !== 0 || stall_bad !== 0 || done_cnt !== 1) begin
        errors++; $display("FAIL random_dump it %0d (%0d x %0d): bad %0d unstable %0d done %0d expected 0 0 1",
          it, ni, nq, dump_mismatches(clampn(ni), clampn(nq)), stall_bad, done_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_dump;
    int dcnt, vcnt;
    dcnt = 0; vcnt = 0;
    bus.i_bin_num = 8'd16; bus.q_bin_num = 8'd16;
    bus.dump_start = 1'b1; bus.out_ready = 1'b1;
    tick;
    bus.dump_start = 1'b0;
    repeat (5) tick;
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_dump_active: valid %b expected 1", bus.out_valid); end
    rst = 1'b1;
    tick;
    checks++;
    if ({bus.out_valid, bus.busy, bus.done, bus.drop_err, bus.range_err} !== 5'b0) begin
      errors++; $display("FAIL mid_dump_reset: got %b expected 00000",
        {bus.out_valid, bus.busy, bus.done, bus.drop_err, bus.range_err});
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (bus.done) dcnt++;
      if (bus.out_valid) vcnt++;
    end
    checks++;
    if (dcnt !== 0 || vcnt !== 0) begin
      errors++; $display("FAIL mid_dump_after: done %0d valid %0d expected 0 0", dcnt, vcnt);
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs;
    test_reset;
    test_clear;
    test_updates;
    test_stall;
    test_range;
    test_drop;
    test_collision;
    test_updates;
    test_empty;
    test_clamp;
    test_random;
    test_reset_mid_dump;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
